// File: rtl/frame_ack_tx.sv
// frame_ack_tx
//   UART (8N1) status transmitter for the host return path. Each frame_done
//   pulse queues a packet {SYNC_BYTE, {5'b0, count[10:8]}, count[7:0]}.
//   The packet carries the point count of the frame that just finished.
//   A one-deep pending slot absorbs a request that arrives while a packet
//   is in flight.
//
//   Build option: define FRAME_ACK_CHECKSUM_EN to append a 4th byte. That
//   byte is the XOR of the three preceding bytes.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   frame_done  single-cycle pulse: a frame has been fully drawn
//   num_points  point count of that frame, valid with frame_done
//   tx          UART serial out, idle high
//   busy        high while a packet is being shifted out
//   overrun     sticky: a request arrived while another was still pending
module frame_ack_tx #(
    parameter int          CLKS_PER_BIT = 104,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_done,
    input  logic [10:0] num_points,
    output logic        tx,
    output logic        busy,
    output logic        overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);

`ifdef FRAME_ACK_CHECKSUM_EN
    localparam logic [1:0] LAST_BYTE = 2'd3;
`else
    localparam logic [1:0] LAST_BYTE = 2'd2;
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state, state_n;
    logic [CW-1:0] clk_cnt, clk_cnt_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [1:0]  byte_idx, byte_idx_n;
    logic [10:0] shadow, shadow_n;
    logic [10:0] pend_cnt, pend_cnt_n;
    logic        pending, pending_n;
    logic        overrun_n;
    logic        tx_n, busy_n;
    logic        bit_end, consume;
    logic [7:0]  cur_byte;

    function automatic logic [7:0] pkt_byte(input logic [1:0] idx, input logic [10:0] cnt);
        logic [7:0] b;
        case (idx)
            2'd0:    b = SYNC_BYTE;
            2'd1:    b = {5'b0, cnt[10:8]};
`ifdef FRAME_ACK_CHECKSUM_EN
            2'd3:    b = SYNC_BYTE ^ {5'b0, cnt[10:8]} ^ cnt[7:0];
`endif
            default: b = cnt[7:0];
        endcase
        return b;
    endfunction

    always_comb begin
        state_n    = state;
        clk_cnt_n  = clk_cnt;
        bit_idx_n  = bit_idx;
        byte_idx_n = byte_idx;

        bit_end = (clk_cnt == CW'(CLKS_PER_BIT - 1));
        // Every request passes through the pending slot, so an IDLE request
        // starts one edge after it is sampled.
        consume = (state == IDLE) && pending;

        case (state)
            IDLE: begin
                if (pending) begin
                    state_n    = START;
                    clk_cnt_n  = '0;
                    bit_idx_n  = '0;
                    byte_idx_n = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n   = DATA;
                    clk_cnt_n = '0;
                    bit_idx_n = '0;
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    if (bit_idx == 3'd7) state_n = STOP;
                    else                 bit_idx_n = bit_idx + 3'd1;
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    if (byte_idx == LAST_BYTE) begin
                        state_n    = IDLE;
                        byte_idx_n = '0;
                    end else begin
                        state_n    = START;
                        byte_idx_n = byte_idx + 2'd1;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        shadow_n   = consume ? pend_cnt : shadow;
        pend_cnt_n = frame_done ? num_points : pend_cnt;
        pending_n  = frame_done ? 1'b1 : (consume ? 1'b0 : pending);
        // The consume cycle hands the old request to the shifter, so a new
        // pulse there simply refills the slot.
        overrun_n  = overrun | (frame_done & pending & ~consume);

        // tx and busy are registered from next-state values to keep the pin
        // glitch-free while still reacting on the same edge as the FSM.
        cur_byte = pkt_byte(byte_idx_n, shadow_n);
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = cur_byte[bit_idx_n];
            default: tx_n = 1'b1;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            shadow   <= '0;
            pend_cnt <= '0;
            pending  <= 1'b0;
            overrun  <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            clk_cnt  <= clk_cnt_n;
            bit_idx  <= bit_idx_n;
            byte_idx <= byte_idx_n;
            shadow   <= shadow_n;
            pend_cnt <= pend_cnt_n;
            pending  <= pending_n;
            overrun  <= overrun_n;
            tx       <= tx_n;
            busy     <= busy_n;
        end
    end

endmodule

// File: tb/tb_frame_ack_tx.sv
// Bench for frame_ack_tx at CLKS_PER_BIT=4. It decodes the tx line as UART
// frames and measures busy pulses and idle gaps. Results are compared
// against a timing model of request arrival and packet scheduling.
module tb_frame_ack_tx;
    localparam int CPB = 4;
`ifdef FRAME_ACK_CHECKSUM_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif
    localparam int L = NB * 10 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_done = 1'b0;
    logic [10:0] num_points = '0;
    logic        tx, busy, overrun;

    frame_ack_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .reset(rst), .frame_done(frame_done), .num_points(num_points),
        .tx(tx), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc++;

    int ncmp = 0;
    int nfail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- line monitor ----------------
    bit         rx_active;
    int         rx_pos, unstable, bad_stop, brun, irun;
    bit         have_pkt;
    logic [7:0] sh;
    logic       bit_first;
    logic [7:0] rx_q[$];
    int         busy_q[$];
    int         idle_q[$];

    always @(negedge clk) begin
        if (rst) begin
            rx_active = 0; rx_pos = 0; unstable = 0; bad_stop = 0;
            brun = 0; irun = 0; have_pkt = 0;
            rx_q.delete(); busy_q.delete(); idle_q.delete();
        end else begin
            if (busy === 1'b1) begin
                if (have_pkt && brun == 0) idle_q.push_back(irun);
                brun++;
                irun = 0;
            end else begin
                if (brun > 0) begin
                    busy_q.push_back(brun);
                    have_pkt = 1;
                    brun = 0;
                end
                irun++;
            end
            if (!rx_active) begin
                if (tx === 1'b0) begin
                    rx_active = 1;
                    rx_pos = 0;
                end
            end else begin
                rx_pos++;
            end
            if (rx_active) begin
                if (rx_pos % CPB == 0) bit_first = tx;
                else if (tx !== bit_first) unstable++;
                if (rx_pos % CPB == CPB - 1) begin
                    int k;
                    k = rx_pos / CPB;
                    if (k >= 1 && k <= 8) sh[k-1] = tx;
                    if (k == 9) begin
                        if (tx !== 1'b1) bad_stop++;
                        rx_q.push_back(sh);
                        rx_active = 0;
                    end
                end
            end
        end
    end

    // ---------------- reference model ----------------
    // Each request is handled by arrival edge arithmetic. A packet requested
    // while the line is free starts one edge later. A request made up to and
    // including the edge where busy falls waits in a single slot. That slot
    // starts one edge after the preceding packet ends.
    longint     last_end;
    bit         m_pend;
    logic [10:0] m_pcnt;
    bit         m_ovr;
    int         npk;
    logic [7:0] exp_b[$];
    int         exp_gap[$];

    task automatic model_clear();
        last_end = -100000; m_pend = 0; m_pcnt = '0; m_ovr = 0; npk = 0;
        exp_b.delete(); exp_gap.delete();
    endtask

    task automatic emit(input logic [10:0] c, input longint s);
        logic [7:0] hi, lo;
        hi = {5'b0, c[10:8]};
        lo = c[7:0];
        exp_b.push_back(8'hA5); exp_b.push_back(hi); exp_b.push_back(lo);
`ifdef FRAME_ACK_CHECKSUM_EN
        exp_b.push_back(8'hA5 ^ hi ^ lo);
`endif
        if (npk > 0) exp_gap.push_back(int'(s - last_end));
        last_end = s + L;
        npk++;
    endtask

    task automatic settle(input longint t);
        if (m_pend && t >= last_end + 1) begin
            emit(m_pcnt, last_end + 1);
            m_pend = 0;
        end
    endtask

    task automatic request(input longint t, input logic [10:0] c);
        settle(t);
        if (!m_pend && t > last_end) begin
            emit(c, t + 1);
        end else begin
            if (m_pend) m_ovr = 1;
            m_pend = 1;
            m_pcnt = c;
        end
    endtask

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic pulse(input logic [10:0] c);
        frame_done = 1'b1;
        num_points = c;
        request(cyc, c);
        @(negedge clk);
        frame_done = 1'b0;
        num_points = 11'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
    endtask

    task automatic session_check(input string name);
        longint n;
        int nb, np, ng;
        settle(64'h3fff_ffff_ffff_ffff);
        n = last_end - cyc + 10;
        if (n < 2) n = 2;
        repeat (n) @(negedge clk);
        @(posedge clk);
        #1;
        check({name, ".idle_tx"}, tx, 1'b1);
        check({name, ".idle_busy"}, busy, 1'b0);
        check({name, ".overrun"}, overrun, m_ovr);
        check({name, ".unstable_bits"}, unstable, 0);
        check({name, ".bad_stop"}, bad_stop, 0);
        check({name, ".nbytes"}, rx_q.size(), exp_b.size());
        nb = (rx_q.size() < exp_b.size()) ? rx_q.size() : exp_b.size();
        for (int i = 0; i < nb; i++)
            check($sformatf("%s.byte%0d", name, i), rx_q[i], exp_b[i]);
        check({name, ".npkt"}, busy_q.size(), npk);
        np = (busy_q.size() < npk) ? busy_q.size() : npk;
        for (int i = 0; i < np; i++)
            check($sformatf("%s.busy_len%0d", name, i), busy_q[i], L);
        check({name, ".ngaps"}, idle_q.size(), exp_gap.size());
        ng = (idle_q.size() < exp_gap.size()) ? idle_q.size() : exp_gap.size();
        for (int i = 0; i < ng; i++)
            check($sformatf("%s.gap%0d", name, i), idle_q[i], exp_gap[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // quiet line after reset
        for (int i = 0; i < 1000; i++) begin
            check("quiet.tx", tx, 1'b1);
            check("quiet.busy", busy, 1'b0);
            check("quiet.overrun", overrun, 1'b0);
            @(negedge clk);
        end

        // single packet with latency check
        do_reset();
        pulse(11'h5C3);
        check("lat.tx_edgeN", tx, 1'b1);
        check("lat.busy_edgeN", busy, 1'b0);
        @(negedge clk);
        check("lat.tx_edgeN1", tx, 1'b0);
        check("lat.busy_edgeN1", busy, 1'b1);
        session_check("single");

        // queued request while busy
        do_reset();
        pulse(11'd3);
        repeat (19) @(negedge clk);
        pulse(11'd700);
        session_check("queued");

        // two requests while busy: newest wins, overrun sticks
        do_reset();
        pulse(11'd3);
        repeat (10) @(negedge clk);
        pulse(11'd10);
        repeat (10) @(negedge clk);
        pulse(11'd20);
        session_check("overrun");
        repeat (50) @(negedge clk);
        check("overrun.sticky", overrun, 1'b1);
        do_reset();
        check("overrun.cleared", overrun, 1'b0);

        // asynchronous reset mid data bit 1 of the second byte (a zero bit)
        pulse(11'h5C3);
        repeat (12 * CPB + 2) @(posedge clk);
        #2;
        check("areset.pre_tx", tx, 1'b0);
        check("areset.pre_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("areset.tx", tx, 1'b1);
        check("areset.busy", busy, 1'b0);
        check("areset.overrun", overrun, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_clear();
        repeat (5) @(negedge clk);
        pulse(11'h2AB);
        session_check("after_areset");

        // randomized request streams, including pulses near packet end
        for (int s = 0; s < 3; s++) begin
            do_reset();
            for (int k = 0; k < 6; k++) begin
                int g;
                case ($urandom_range(0, 2))
                    0:       g = $urandom_range(0, 15);
                    1:       g = $urandom_range(L - 3, L + 3);
                    default: g = $urandom_range(L + 5, 2 * L);
                endcase
                repeat (g) @(negedge clk);
                pulse(11'($urandom_range(0, 2047)));
            end
            session_check($sformatf("rand%0d", s));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
